brownout_dig: RTL and testbench
===============================

Name: brownout_dig

Overview:
- Digital control stage sitting directly around the brownout analog core.
- Decodes the 3-bit trip-select codes into the one-hot `otrip_decoded`/`vtrip_decoded` buses the analog resistor-string mux consumes.
- Drives `osc_ena` to the RC oscillator and is clocked by its `osc_ck`.
- Synchronises and debounces the comparator output `brout_filt`, then produces `out_unbuf` with a guaranteed minimum hold time after the supply recovers.

Parameters:
- DEB_CYC, 4: consecutive synchronised `brout_filt`=1 samples required before tripping (range 1..15).
- HOLD_CYC, 64: `osc_ck` cycles `out_unbuf` stays high after `brout_filt` clears (range 2..255).
- HOLD_SHORT, 2: hold length used when `force_short_oneshot`=1.

Ports:
- osc_ck  input  1  block clock, from the RC oscillator
- rst  input  1  asynchronous, active-high reset
- ena  input  1  block enable, dvdd domain
- otrip  input  3  brownout trip-level select
- vtrip  input  3  undervoltage trip-level select
- brout_filt  input  1  raw comparator output; 1 = supply below trip; asynchronous to `osc_ck`
- force_ena_rc_osc  input  1  test: force oscillator on
- force_dis_rc_osc  input  1  test: force oscillator off (wins over force_ena)
- force_short_oneshot  input  1  test: use HOLD_SHORT instead of HOLD_CYC
- otrip_decoded  output  8  one-hot of `otrip`
- vtrip_decoded  output  8  one-hot of `vtrip`
- osc_ena  output  1  RC oscillator enable
- out_unbuf  output  1  brownout flag, registered
- timed_out  output  1  one-cycle pulse when a hold interval expires

Behaviour:
- Clocking and reset:
  - One clock (`osc_ck`).
  - Reset is asynchronous, active-high, on `rst`.
  - All flops clear on `rst`=1.
- Reset values:
  - `out_unbuf`=0, `timed_out`=0, state=IDLE, counters=0.
  - `otrip_decoded`=8'h01 and `vtrip_decoded`=8'h01 (code 0).
- Decode:
  - Registered: `otrip_decoded[k]`=1 iff `otrip`==k; `vtrip_decoded` likewise.
  - Updates one cycle after the code changes.
  - Exactly one bit is high at all times, including while `ena`=0.
- Synchroniser:
  - 2-flop chain on `brout_filt`, producing `bsync`.
  - Latency is 2 cycles before the FSM sees any change.
- `osc_ena`:
  - Combinational: `osc_ena` = (`ena` | `force_ena_rc_osc`) & ~`force_dis_rc_osc`.
- FSM states:
  - IDLE: `out_unbuf`=0. Go to MONITOR when `ena`=1.
  - MONITOR: `out_unbuf`=0; deb_cnt=0. If `bsync`=1, go to DEBOUNCE with deb_cnt=1.
  - DEBOUNCE: `out_unbuf`=0.
    - If `bsync`=0, go back to MONITOR.
    - If `bsync`=1, deb_cnt increments; when deb_cnt reaches DEB_CYC, go to TRIPPED.
    - With DEB_CYC=1, go straight from MONITOR to TRIPPED.
  - TRIPPED: `out_unbuf`=1. When `bsync`=0, go to HOLD with hold_cnt=0.
  - HOLD: `out_unbuf`=1; hold_cnt increments each cycle.
    - If `bsync`=1, return to TRIPPED and reset hold_cnt; the hold restarts.
    - If hold_cnt == limit-1, pulse `timed_out` for 1 cycle and go to MONITOR. `out_unbuf` falls in the same cycle.
    - limit = HOLD_SHORT when `force_short_oneshot`=1, else HOLD_CYC.
    - `force_short_oneshot` is sampled every cycle. If it is asserted mid-hold with hold_cnt ≥ HOLD_SHORT-1, exit on the next cycle.
- `ena`=0 in any state: go to IDLE next cycle, clear `out_unbuf` and counters, no `timed_out` pulse.
- Mid-operation reset: `rst` asserted in any state forces the reset values immediately; `osc_ena` follows its inputs.
- Counter widths: deb_cnt 4 bits; hold_cnt 8 bits. No wrap is possible given the parameter ranges.

Optional Feature:
- Macro: BROWNOUT_EVCNT_EN.
- Defined:
  - Adds output `brout_evcnt` [7:0].
  - It increments on every DEBOUNCE→TRIPPED transition and saturates at 8'hFF.
  - It is cleared by `rst` only; `ena`=0 does not clear it.
  - HOLD→TRIPPED re-entry does not count.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package `brownout_pkg`:
  - State enum `brout_state_t` {IDLE, MONITOR, DEBOUNCE, TRIPPED, HOLD}.
  - Counter width localparams DEB_W=4, HOLD_W=8.
  - Function `onehot8(logic [2:0])`.
- One sub-module, `brout_sync2`: the 2-flop synchroniser with asynchronous reset. Instantiated once for `brout_filt`.

Test Plan:
- Reset, then `ena`=1, `otrip`=5, `vtrip`=2 → next cycle `otrip_decoded`=8'h20, `vtrip_decoded`=8'h04, `out_unbuf`=0, `osc_ena`=1.
- `brout_filt`=1 for 3 cycles, then 0 (DEB_CYC=4) → `out_unbuf` never rises.
- `brout_filt`=1 held → `out_unbuf` rises exactly 2+4 cycles after the edge. Then release → `out_unbuf` stays 1 for 64 cycles after HOLD entry, with `timed_out` pulsing on its falling cycle.
- Recovery glitch: `brout_filt` pulses to 1 at hold cycle 30 → return to TRIPPED; the full 64-cycle hold restarts after release.
- `force_short_oneshot`=1 → hold lasts 2 cycles. `force_dis_rc_osc`=1 together with `force_ena_rc_osc`=1 → `osc_ena`=0.
- `rst` pulsed asynchronously mid-HOLD → `out_unbuf`=0 with no clock edge. With BROWNOUT_EVCNT_EN, 300 trips → `brout_evcnt`=8'hFF.

Source files
------------

// File: rtl/brownout_pkg.sv
// Shared definitions for the brownout digital control stage:
// FSM state encoding, counter widths and the trip-code one-hot decode.
package brownout_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MONITOR,
        DEBOUNCE,
        TRIPPED,
        HOLD
    } brout_state_t;

    localparam int DEB_W  = 4;
    localparam int HOLD_W = 8;

    function automatic logic [7:0] onehot8(input logic [2:0] code);
        logic [7:0] v;
        v = 8'h01 << code;
        return v;
    endfunction

endpackage

// File: rtl/brout_sync2.sv
// Two-flop synchroniser for a single asynchronous level into the osc_ck domain.
module brout_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/brownout_dig.sv
// Brownout digital control: trip-code decode, oscillator enable, comparator
// sync/debounce and minimum-hold output. Optional event counter: BROWNOUT_EVCNT_EN.
module brownout_dig
    import brownout_pkg::*;
#(
    parameter int DEB_CYC    = 4,
    parameter int HOLD_CYC   = 64,
    parameter int HOLD_SHORT = 2
) (
    input  logic       osc_ck,
    input  logic       rst,
    input  logic       ena,
    input  logic [2:0] otrip,
    input  logic [2:0] vtrip,
    input  logic       brout_filt,
    input  logic       force_ena_rc_osc,
    input  logic       force_dis_rc_osc,
    input  logic       force_short_oneshot,
    output logic [7:0] otrip_decoded,
    output logic [7:0] vtrip_decoded,
    output logic       osc_ena,
    output logic       out_unbuf,
`ifdef BROWNOUT_EVCNT_EN
    output logic [7:0] brout_evcnt,
`endif
    output logic       timed_out
);

    localparam logic [DEB_W-1:0]  LP_DEB_LAST   = DEB_W'(DEB_CYC - 1);
    localparam logic [HOLD_W-1:0] LP_HOLD_LONG  = HOLD_W'(HOLD_CYC - 1);
    localparam logic [HOLD_W-1:0] LP_HOLD_SHORT = HOLD_W'(HOLD_SHORT - 1);

    brout_state_t        r_state;
    logic [DEB_W-1:0]    r_deb_cnt;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic                r_out;
    logic                r_timed_out;
    logic [7:0]          r_otrip_dec;
    logic [7:0]          r_vtrip_dec;
    logic                w_bsync;
    logic [HOLD_W-1:0]   w_hold_last;

    brout_sync2 u_sync (
        .clk (osc_ck),
        .rst (rst),
        .d   (brout_filt),
        .q   (w_bsync)
    );

    assign osc_ena     = (ena | force_ena_rc_osc) & ~force_dis_rc_osc;
    assign w_hold_last = force_short_oneshot ? LP_HOLD_SHORT : LP_HOLD_LONG;

    always_ff @(posedge osc_ck or posedge rst) begin
        if (rst) begin
            r_otrip_dec <= 8'h01;
            r_vtrip_dec <= 8'h01;
        end else begin
            r_otrip_dec <= onehot8(otrip);
            r_vtrip_dec <= onehot8(vtrip);
        end
    end

    always_ff @(posedge osc_ck or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_deb_cnt   <= '0;
            r_hold_cnt  <= '0;
            r_out       <= 1'b0;
            r_timed_out <= 1'b0;
        end else begin
            r_timed_out <= 1'b0;
            if (!ena) begin
                r_state    <= IDLE;
                r_deb_cnt  <= '0;
                r_hold_cnt <= '0;
                r_out      <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_out   <= 1'b0;
                        r_state <= MONITOR;
                    end
                    MONITOR: begin
                        r_out      <= 1'b0;
                        r_deb_cnt  <= '0;
                        r_hold_cnt <= '0;
                        if (w_bsync) begin
                            if (DEB_CYC == 1) begin
                                r_state <= TRIPPED;
                                r_out   <= 1'b1;
                            end else begin
                                r_state   <= DEBOUNCE;
                                r_deb_cnt <= DEB_W'(1);
                            end
                        end
                    end
                    DEBOUNCE: begin
                        if (!w_bsync) begin
                            r_state   <= MONITOR;
                            r_deb_cnt <= '0;
                        end else if (r_deb_cnt == LP_DEB_LAST) begin
                            r_state   <= TRIPPED;
                            r_out     <= 1'b1;
                            r_deb_cnt <= '0;
                        end else begin
                            r_deb_cnt <= r_deb_cnt + 1'b1;
                        end
                    end
                    TRIPPED: begin
                        r_out      <= 1'b1;
                        r_hold_cnt <= '0;
                        if (!w_bsync) begin
                            r_state <= HOLD;
                        end
                    end
                    HOLD: begin
                        // >= lets a mid-hold switch to the short limit exit at once
                        if (w_bsync) begin
                            r_state    <= TRIPPED;
                            r_hold_cnt <= '0;
                        end else if (r_hold_cnt >= w_hold_last) begin
                            r_state     <= MONITOR;
                            r_out       <= 1'b0;
                            r_timed_out <= 1'b1;
                            r_hold_cnt  <= '0;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_out   <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef BROWNOUT_EVCNT_EN
    logic [7:0] r_evcnt;
    logic       w_trip_evt;

    assign w_trip_evt = ena & w_bsync &
                        (((r_state == DEBOUNCE) && (r_deb_cnt == LP_DEB_LAST)) ||
                         ((r_state == MONITOR) && (DEB_CYC == 1)));

    always_ff @(posedge osc_ck or posedge rst) begin
        if (rst) begin
            r_evcnt <= '0;
        end else if (w_trip_evt && (r_evcnt != '1)) begin
            r_evcnt <= r_evcnt + 1'b1;
        end
    end

    assign brout_evcnt = r_evcnt;
`endif

    assign otrip_decoded = r_otrip_dec;
    assign vtrip_decoded = r_vtrip_dec;
    assign out_unbuf     = r_out;
    assign timed_out     = r_timed_out;

endmodule

// File: tb/tb_brownout_dig.sv
// Directed scoreboard bench for brownout_dig; also covers the event counter
// when BROWNOUT_EVCNT_EN is defined.
module tb_brownout_dig;

    logic       osc_ck = 1'b0;
    logic       rst;
    logic       ena;
    logic [2:0] otrip;
    logic [2:0] vtrip;
    logic       brout_filt;
    logic       force_ena_rc_osc;
    logic       force_dis_rc_osc;
    logic       force_short_oneshot;
    logic [7:0] otrip_decoded;
    logic [7:0] vtrip_decoded;
    logic       osc_ena;
    logic       out_unbuf;
    logic       timed_out;
`ifdef BROWNOUT_EVCNT_EN
    logic [7:0] brout_evcnt;
    int         n_trips;
`endif

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_chk;
    int   n_fail;

    brownout_dig #(
        .DEB_CYC    (4),
        .HOLD_CYC   (64),
        .HOLD_SHORT (2)
    ) dut (
        .osc_ck              (osc_ck),
        .rst                 (rst),
        .ena                 (ena),
        .otrip               (otrip),
        .vtrip               (vtrip),
        .brout_filt          (brout_filt),
        .force_ena_rc_osc    (force_ena_rc_osc),
        .force_dis_rc_osc    (force_dis_rc_osc),
        .force_short_oneshot (force_short_oneshot),
        .otrip_decoded       (otrip_decoded),
        .vtrip_decoded       (vtrip_decoded),
        .osc_ena             (osc_ena),
        .out_unbuf           (out_unbuf),
`ifdef BROWNOUT_EVCNT_EN
        .brout_evcnt         (brout_evcnt),
`endif
        .timed_out           (timed_out)
    );

    always #5 osc_ck = ~osc_ck;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no end, expected $finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge osc_ck);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        n_chk++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_empty: observed %h, expected a queued value", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $display("FAIL %s: observed %h, expected %h", e.tag, obs, e.val);
                $error("%s observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst = 1'b0;
        ena = 1'b0;
        otrip = 3'd0;
        vtrip = 3'd0;
        brout_filt = 1'b0;
        force_ena_rc_osc = 1'b0;
        force_dis_rc_osc = 1'b0;
        force_short_oneshot = 1'b0;
`ifdef BROWNOUT_EVCNT_EN
        n_trips = 0;
`endif

        #3 rst = 1'b1;
        repeat (2) tick();
        push("rst_flag", 32'h0);
        chk(32'({timed_out, out_unbuf}));
        push("rst_decode", 32'h0101);
        chk(32'({otrip_decoded, vtrip_decoded}));
        rst = 1'b0;
        tick();

        // Decode stays one-hot while disabled
        for (int k = 0; k < 8; k++) begin
            otrip = 3'(k);
            vtrip = 3'(7 - k);
            push("decode_ena0", 32'((16'h0100 << k) | (16'h0001 << (7 - k))));
            tick();
            chk(32'({otrip_decoded, vtrip_decoded}));
        end

        ena = 1'b1;
        otrip = 3'd5;
        vtrip = 3'd2;
        push("decode_5_2", 32'h2004);
        push("en_flag", 32'h0);
        push("en_osc", 32'h1);
        tick();
        chk(32'({otrip_decoded, vtrip_decoded}));
        chk(32'({timed_out, out_unbuf}));
        chk(32'(osc_ena));
        repeat (3) tick();

        // Three-cycle glitch must not trip
        brout_filt = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            push("short_glitch", 32'h0);
            tick();
            chk(32'({timed_out, out_unbuf}));
            if (i == 3) brout_filt = 1'b0;
        end

        // Sustained trip: rises 6 edges after input edge, then 64-cycle hold
        brout_filt = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            push("trip_rise", (i >= 6) ? 32'h1 : 32'h0);
            tick();
            chk(32'({timed_out, out_unbuf}));
        end
        brout_filt = 1'b0;
        for (int i = 1; i <= 68; i++) begin
            push("hold_long", (i <= 66) ? 32'h1 : ((i == 67) ? 32'h2 : 32'h0));
            tick();
            chk(32'({timed_out, out_unbuf}));
        end

        // Glitch during hold restarts the full hold
        brout_filt = 1'b1;
        repeat (8) tick();
        brout_filt = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            push("hold_restart", (i <= 97) ? 32'h1 : ((i == 98) ? 32'h2 : 32'h0));
            tick();
            chk(32'({timed_out, out_unbuf}));
            if (i == 30) brout_filt = 1'b1;
            if (i == 31) brout_filt = 1'b0;
        end

        // Short one-shot hold
        force_short_oneshot = 1'b1;
        brout_filt = 1'b1;
        repeat (8) tick();
        brout_filt = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            push("hold_short", (i <= 4) ? 32'h1 : ((i == 5) ? 32'h2 : 32'h0));
            tick();
            chk(32'({timed_out, out_unbuf}));
        end
        force_short_oneshot = 1'b0;

        // Disable while tripped: clears next cycle without timed_out
        brout_filt = 1'b1;
        repeat (8) tick();
        push("tripped_pre_dis", 32'h1);
        chk(32'({timed_out, out_unbuf}));
        ena = 1'b0;
        push("dis_clear", 32'h0);
        tick();
        chk(32'({timed_out, out_unbuf}));
        brout_filt = 1'b0;
        repeat (3) tick();
        push("dis_stay", 32'h0);
        chk(32'({timed_out, out_unbuf}));

        // osc_ena truth table: {ena, force_ena, force_dis} -> expected
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            ena = v[2];
            force_ena_rc_osc = v[1];
            force_dis_rc_osc = v[0];
            push("osc_ena", 32'((v[2] | v[1]) & ~v[0]));
            #1;
            chk(32'(osc_ena));
        end
        ena = 1'b1;
        force_ena_rc_osc = 1'b0;
        force_dis_rc_osc = 1'b0;
        repeat (3) tick();

        // Asynchronous reset mid-hold
        brout_filt = 1'b1;
        repeat (8) tick();
        brout_filt = 1'b0;
        repeat (13) tick();
        push("hold_pre_rst", 32'h1);
        chk(32'({timed_out, out_unbuf}));
        #2 rst = 1'b1;
        #1;
        push("async_rst_flag", 32'h0);
        chk(32'({timed_out, out_unbuf}));
        push("async_rst_decode", 32'h0101);
        chk(32'({otrip_decoded, vtrip_decoded}));
        @(negedge osc_ck);
        rst = 1'b0;
        repeat (3) tick();

`ifdef BROWNOUT_EVCNT_EN
        push("evcnt_reset", 32'h0);
        chk(32'(brout_evcnt));
        force_short_oneshot = 1'b1;
        for (int t = 1; t <= 300; t++) begin
            brout_filt = 1'b1;
            repeat (6) tick();
            brout_filt = 1'b0;
            repeat (6) tick();
            n_trips++;
            if (t == 1) begin
                push("evcnt_first", 32'(n_trips));
                chk(32'(brout_evcnt));
            end
        end
        push("evcnt_sat", (n_trips > 255) ? 32'd255 : 32'(n_trips));
        chk(32'(brout_evcnt));
        force_short_oneshot = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
